ahb_mem_slave: RTL

Parametrised AHB-Lite memory slave. Successor to the single-state write-echo slave.
- Adds HSEL decoding, a pipelined address/data phase, and a word-addressed memory with byte lanes.
- Adds programmable wait states and a two-cycle ERROR response.
- Bursts (SINGLE, INCR, INCR4/8/16, WRAP4/8/16) are handled beat by beat from the master-supplied addresses.
- Sits behind the AHB-Lite decoder/mux as a bus target for the burst master.

---
 rtl/ahb_pkg.sv | 20 ++
 rtl/ahb_slave_mem.sv | 25 ++
 rtl/ahb_mem_slave.sv | 82 ++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite codes, slave FSM encodings and byte-lane helper
package ahb_pkg;
   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_BUSY   = 2'b01;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;
   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;
   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;
   // little-endian lane enables for a legal (aligned) transfer
   function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] a);
      return size == SIZE_BYTE ? 4'b0001 << a : size == SIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction
endpackage

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: DEPTHx32 synchronous RAM, byte-enable write port, registered read port
//   HCLK/HRESET: clock, sync reset (clears only the read register)
//   we/be/waddr/wdata: byte-lane write; re/raddr/rdata: registered read, holds when re=0
module ahb_slave_mem #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];
   always_ff @(posedge HCLK) begin
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      if (HRESET) rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite memory slave with byte lanes, wait states, ERROR response, RAW forwarding
//   HCLK/HRESET: clock, sync active-high reset
//   HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS/HREADY: address phase; HWDATA: write data phase
//   HREADYOUT/HRESP/HRDATA: slave response
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [1:0]        HTRANS,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA
);
   localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4*MEM_DEPTH);
   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          dp_valid, dp_write;
   logic [AW+1:0] dp_addr;
   logic [2:0]    dp_size;
   logic          accept, bad, complete, we, rd_en, hit;
   logic [AW-1:0] rd_addr;
   logic [3:0]    be, fwd_be;
   logic [31:0]   ram_q, fwd_data, fwd_mask;
   logic          unused;
   assign unused = ^{HBURST, HTRANS[0]};
   assign HREADYOUT = state == ST_IDLE || state == ST_ERR2;
   assign HRESP = state == ST_ERR1 || state == ST_ERR2 ? RESP_ERROR : RESP_OKAY;
   // our own HREADYOUT also gates accept so a stalled phase can never be overwritten
   assign accept = HSEL && HREADY && HTRANS[1] && HREADYOUT;
   assign bad = HSIZE > SIZE_WORD || (HSIZE == SIZE_HALF && HADDR[0]) ||
                (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00) || {1'b0, HADDR} >= MEM_BYTES;
   assign complete = HREADYOUT && dp_valid;
   assign we = complete && dp_write && !HRESET;
   assign be = lane_be(dp_size, dp_addr[1:0]);
   // zero-wait reads fetch at accept; with waits, on the last wait cycle
   assign rd_en = WAIT_STATES == 0 ? accept && !bad && !HWRITE : state == ST_WAIT && cnt == 4'd1 && !dp_write;
   assign rd_addr = WAIT_STATES == 0 ? HADDR[AW+1:2] : dp_addr[AW+1:2];
   assign hit = we && rd_en && rd_addr == dp_addr[AW+1:2];
   assign fwd_mask = {{8{fwd_be[3]}}, {8{fwd_be[2]}}, {8{fwd_be[1]}}, {8{fwd_be[0]}}};
   assign HRDATA = (ram_q & ~fwd_mask) | (fwd_data & fwd_mask);
   ahb_slave_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
      .HCLK(HCLK), .HRESET(HRESET), .we(we), .be(be), .waddr(dp_addr[AW+1:2]), .wdata(HWDATA),
      .re(rd_en), .raddr(rd_addr), .rdata(ram_q)
   );
   // lanes written on the same edge the RAM is read are overlaid on its stale output
   always_ff @(posedge HCLK)
      if (HRESET) fwd_be <= '0;
      else if (rd_en) begin
         fwd_be <= hit ? be : 4'b0000;
         fwd_data <= HWDATA;
      end
   always_ff @(posedge HCLK)
      if (HRESET) begin
         state <= ST_IDLE;
         cnt <= '0;
         dp_valid <= 1'b0;
      end else begin
         if (accept) begin
            dp_addr <= HADDR[AW+1:0];
            dp_write <= HWRITE;
            dp_size <= HSIZE;
         end
         dp_valid <= accept ? !bad : complete ? 1'b0 : dp_valid;
         state <= state == ST_ERR1 ? ST_ERR2
                : state == ST_WAIT ? (cnt == 4'd1 ? ST_IDLE : ST_WAIT)
                : accept ? (bad ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_IDLE) : ST_IDLE;
         cnt <= state == ST_WAIT ? cnt - 4'd1 : accept && !bad ? 4'(WAIT_STATES) : 4'd0;
      end
endmodule
